// File: rtl/pixel_stream_tx_if.sv
// Frame-memory read port plus raster pixel stream for pixel_stream_tx.
// The master side is the transmitter; the slave side is the memory together with the pixel consumer.
interface pixel_stream_tx_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] pixel_data;
  logic              data_en;
  logic              sof;
  logic              eol;

  modport master (
    output mem_rd_en, mem_addr, pixel_data, data_en, sof, eol,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, pixel_data, data_en, sof, eol,
    output mem_rd_data
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// Reads one IMAGE_W x IMAGE_H frame from synchronous-read memory in raster order and
// streams it as pixel_data/data_en with an HBLANK-cycle idle gap after each line.
//
//  state     | meaning
//  ST_IDLE   | waiting for start
//  ST_ACTIVE | issuing one memory read per cycle
//  ST_HBLANK | line gap, no reads
//  ST_FLUSH  | last read issued, waiting for it to leave the pipeline
module pixel_stream_tx #(
  parameter int IMAGE_W = 256,
  parameter int IMAGE_H = 256,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int HBLANK  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  pixel_stream_tx_if.master bus
);
  localparam int COL_W = $clog2(IMAGE_W);
  localparam int ROW_W = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;
  localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_H - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_FLUSH} state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [BLK_W-1:0]  blk, blk_nxt;
  logic              done_nxt;
  logic              rd_en, sof_tag, eol_tag;
  logic              v1, sof1, eol1;
  logic              en, sof_q, eol_q;
  logic [DATA_W-1:0] pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
      blk   <= '0;
      done  <= 1'b0;
      v1    <= 1'b0;
      sof1  <= 1'b0;
      eol1  <= 1'b0;
      en    <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      pix   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      addr  <= addr_nxt;
      blk   <= blk_nxt;
      done  <= done_nxt;
      // tags ride two stages beside the read so they line up with the returned data
      v1    <= rd_en;
      sof1  <= sof_tag;
      eol1  <= eol_tag;
      en    <= v1;
      sof_q <= sof1;
      eol_q <= eol1;
      if (v1) pix <= bus.mem_rd_data;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    addr_nxt  = addr;
    blk_nxt   = blk;
    done_nxt  = 1'b0;
    rd_en     = 1'b0;
    sof_tag   = 1'b0;
    eol_tag   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ACTIVE;
          col_nxt   = '0;
          row_nxt   = '0;
          addr_nxt  = '0;
        end
      end
      ST_ACTIVE: begin
        rd_en    = 1'b1;
        sof_tag  = (col == '0) && (row == '0);
        eol_tag  = (col == COL_LAST);
        addr_nxt = addr + 1'b1;
        if (col == COL_LAST) begin
          col_nxt = '0;
          if (row == ROW_LAST) begin
            state_nxt = ST_FLUSH;
          end else begin
            row_nxt = row + 1'b1;
            if (HBLANK > 0) begin
              state_nxt = ST_HBLANK;
              blk_nxt   = BLK_LOAD;
            end
          end
        end else begin
          col_nxt = col + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (blk == '0) state_nxt = ST_ACTIVE;
        else           blk_nxt   = blk - 1'b1;
      end
      ST_FLUSH: begin
        // with stage 1 empty the last pixel is on the output now; done follows next cycle
        if (!v1) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy           = (state != ST_IDLE) || done;
  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = addr;
  assign bus.pixel_data = pix;
  assign bus.data_en    = en;
  assign bus.sof        = sof_q;
  assign bus.eol        = eol_q;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx: a 4x2 frame with HBLANK=2, the same with HBLANK=0,
// and the default 256x256 frame, each with its own memory model and cycle monitor.
module tb_pixel_stream_tx;
  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_t;

  logic       clk;
  logic [2:0] rst, start;
  logic [2:0] busy_w, done_w;

  int   tests = 0;
  int   fails = 0;
  pix_t exp_q[3][$];
  int   rd_cnt[3], en_cnt[3], gap[3], frames[3];
  bit   h1[3], h2[3], last_px[3], in_gap[3];

  pixel_stream_tx_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  pixel_stream_tx_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();
  pixel_stream_tx_if #(.DATA_W(16), .ADDR_W(16)) bus_c ();

  pixel_stream_tx #(.IMAGE_W(4), .IMAGE_H(2), .DATA_W(16), .ADDR_W(16), .HBLANK(2)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]), .bus(bus_a));
  pixel_stream_tx #(.IMAGE_W(4), .IMAGE_H(2), .DATA_W(16), .ADDR_W(16), .HBLANK(0)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]), .bus(bus_b));
  pixel_stream_tx dut_c (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy_w[2]), .done(done_w[2]), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_a.mem_rd_en) bus_a.mem_rd_data <= bus_a.mem_addr;
  always @(posedge clk) if (bus_b.mem_rd_en) bus_b.mem_rd_data <= bus_b.mem_addr;
  always @(posedge clk) if (bus_c.mem_rd_en) bus_c.mem_rd_data <= bus_c.mem_addr ^ 16'hA5A5;

  task automatic chk(input string name, input int id, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  task automatic mon(input int id, input int w, input int h, input int hb, input logic r,
                     input logic rd, input logic [15:0] addr, input logic en,
                     input logic [15:0] data, input logic sof, input logic eol,
                     input logic dn, input logic bsy);
    pix_t e;
    if (en || h2[id]) chk("en_latency", id, en, h2[id]);
    if (rd) begin
      chk("mem_addr", id, addr, rd_cnt[id]);
      rd_cnt[id]++;
    end
    if (en) begin
      if (exp_q[id].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pixel[%0d]: got data %0d, expected no pixel", id, data);
      end else begin
        e = exp_q[id].pop_front();
        chk("pixel_data", id, data, e.data);
        chk("sof", id, sof, e.sof);
        chk("eol", id, eol, e.eol);
      end
      en_cnt[id]++;
      if (in_gap[id]) begin
        chk("hblank_gap", id, gap[id], hb);
        in_gap[id] = 0;
      end
    end else begin
      if (sof || eol) chk("tag_while_idle", id, {sof, eol}, 0);
      if (in_gap[id]) gap[id]++;
    end
    if (dn || last_px[id]) chk("done_timing", id, dn, last_px[id]);
    if (dn) begin
      chk("busy_in_done", id, bsy, 1);
      chk("reads_per_frame", id, rd_cnt[id], w * h);
      chk("pixels_per_frame", id, en_cnt[id], w * h);
      rd_cnt[id] = 0;
      en_cnt[id] = 0;
      frames[id]++;
    end
    last_px[id] = en && (en_cnt[id] == w * h);
    if (en && eol && en_cnt[id] != w * h) begin
      in_gap[id] = 1;
      gap[id]    = 0;
    end
    h2[id] = h1[id];
    h1[id] = rd;
    if (r) begin
      h1[id] = 0; h2[id] = 0; last_px[id] = 0; in_gap[id] = 0;
      rd_cnt[id] = 0; en_cnt[id] = 0;
      exp_q[id].delete();
    end
  endtask

  always @(negedge clk) mon(0, 4, 2, 2, rst[0], bus_a.mem_rd_en, bus_a.mem_addr, bus_a.data_en,
                            bus_a.pixel_data, bus_a.sof, bus_a.eol, done_w[0], busy_w[0]);
  always @(negedge clk) mon(1, 4, 2, 0, rst[1], bus_b.mem_rd_en, bus_b.mem_addr, bus_b.data_en,
                            bus_b.pixel_data, bus_b.sof, bus_b.eol, done_w[1], busy_w[1]);
  always @(negedge clk) mon(2, 256, 256, 2, rst[2], bus_c.mem_rd_en, bus_c.mem_addr, bus_c.data_en,
                            bus_c.pixel_data, bus_c.sof, bus_c.eol, done_w[2], busy_w[2]);

  task automatic push_frame(input int id, input int w, input int h, input logic [15:0] x);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        p.data = 16'(r * w + c) ^ x;
        p.sof  = (r == 0) && (c == 0);
        p.eol  = (c == w - 1);
        exp_q[id].push_back(p);
      end
  endtask

  task automatic pulse(input int id);
    @(posedge clk); #1 start[id] = 1'b1;
    @(posedge clk); #1 start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done_w[id]) return;
    end
    tests++;
    fails++;
    $display("FAIL done_timeout[%0d]: no done within %0d cycles, expected one", id, bound);
  endtask

  task automatic seq_ab();
    int f0, n;
    bit seen;
    // plain frames on both small instances
    push_frame(0, 4, 2, 16'h0);
    push_frame(1, 4, 2, 16'h0);
    fork
      pulse(0);
      pulse(1);
    join
    fork
      begin wait_done(0, 100); @(negedge clk); chk("busy_after_done", 0, busy_w[0], 0); end
      begin wait_done(1, 100); @(negedge clk); chk("busy_after_done", 1, busy_w[1], 0); end
    join
    chk("frames_plain", 0, frames[0], 1);
    chk("frames_plain", 1, frames[1], 1);

    // start held through the whole frame yields a single frame
    f0 = frames[0];
    push_frame(0, 4, 2, 16'h0);
    @(posedge clk); #1 start[0] = 1'b1;
    repeat (13) @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 20);
    repeat (10) @(negedge clk);
    chk("held_start_frames", 0, frames[0] - f0, 1);
    chk("held_start_leftover", 0, exp_q[0].size(), 0);

    // restart requested in the done cycle
    push_frame(0, 4, 2, 16'h0);
    push_frame(0, 4, 2, 16'h0);
    pulse(0);
    wait_done(0, 100);
    start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus_a.data_en) begin n = k; break; end
    end
    chk("b2b_first_en_after_done", 0, n, 3);
    wait_done(0, 100);
    @(negedge clk);
    chk("b2b_leftover", 0, exp_q[0].size(), 0);

    // reset mid-frame once address 5 has been read
    push_frame(0, 4, 2, 16'h0);
    pulse(0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_a.mem_rd_en && bus_a.mem_addr == 16'd5) begin seen = 1; break; end
    end
    chk("saw_addr5", 0, seen, 1);
    @(posedge clk); #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", 0, bus_a.mem_rd_en, 0);
    chk("abort_data_en", 0, bus_a.data_en, 0);
    chk("abort_busy", 0, busy_w[0], 0);
    chk("abort_done", 0, done_w[0], 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_w[0] || bus_a.data_en) seen = 1;
    end
    chk("abort_quiet", 0, seen, 0);
    push_frame(0, 4, 2, 16'h0);
    pulse(0);
    wait_done(0, 100);
    @(negedge clk);
    chk("replay_leftover", 0, exp_q[0].size(), 0);
  endtask

  task automatic seq_c();
    push_frame(2, 256, 256, 16'hA5A5);
    pulse(2);
    wait_done(2, 70000);
    @(negedge clk);
    chk("busy_after_done", 2, busy_w[2], 0);
    chk("big_leftover", 2, exp_q[2].size(), 0);
    chk("big_frames", 2, frames[2], 1);
  endtask

  initial begin
    rst   = '1;
    start = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, busy_w[0], 0);
    chk("rst_done", 0, done_w[0], 0);
    chk("rst_rd_en", 0, bus_a.mem_rd_en, 0);
    chk("rst_data_en", 0, bus_a.data_en, 0);
    chk("rst_sof_eol", 0, {bus_a.sof, bus_a.eol}, 0);
    chk("rst_mem_addr", 0, bus_a.mem_addr, 0);
    chk("rst_pixel_data", 0, bus_a.pixel_data, 0);
    chk("rst_busy", 1, busy_w[1], 0);
    chk("rst_busy", 2, busy_w[2], 0);
    @(posedge clk); #1 rst = '0;
    fork
      seq_ab();
      seq_c();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
